gem_ext_fifo_tx_wide: RTL and testbench



---
 rtl/gem_ext_fifo_tx_wide_pkg.sv | 26 ++
 rtl/gem_ext_fifo_tx_wide_if.sv | 43 ++++
 rtl/gem_ext_fifo_tx_wide_lane_sel.sv | 47 ++++
 rtl/gem_ext_fifo_tx_wide.sv | 155 +++++++++++++++
 tb/tb_gem_ext_fifo_tx_wide.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gem_ext_fifo_tx_wide_pkg.sv
// Shared types and constants for the wide GEM external-FIFO TX bridge.
// Holds the bridge state enum, the m_status field layout and the GEM status bits.
package gem_ext_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER     = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_END = 2'd3
  } tx_state_e;

  localparam int STAT_TMO_BIT = 4;
  localparam int STAT_GEM_MSB = 3;
  localparam int STAT_GEM_LSB = 0;

  localparam int GEM_STAT_OK_BIT = 0;

  function automatic logic [4:0] make_status(input logic tmo, input logic [3:0] gem_st);
    logic [4:0] st;
    st = '0;
    st[STAT_TMO_BIT] = tmo;
    st[STAT_GEM_MSB:STAT_GEM_LSB] = gem_st;
    return st;
  endfunction

endpackage

// File: rtl/gem_ext_fifo_tx_wide_if.sv
// Stream + GEM external-FIFO TX signal bundle for the wide TX bridge.
// slave = bridge view, master = upstream FIFO / GEM / status consumer view.
interface gem_ext_fifo_tx_wide_if #(
  parameter int S_DATA_WIDTH = 32,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8
);
  logic [S_DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic                    s_axis_tuser;
  logic [7:0]              gem_data;
  logic                    gem_data_ready;
  logic                    gem_data_valid;
  logic                    gem_data_rd_request;
  logic                    gem_sop;
  logic                    gem_eop;
  logic                    gem_err;
  logic                    gem_underflow;
  logic                    gem_control;
  logic                    gem_dma_tx_status_tog;
  logic                    gem_dma_tx_end_tog;
  logic [3:0]              gem_status;
  logic                    m_status_valid;
  logic [4:0]              m_status;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
           gem_data_rd_request, gem_dma_tx_end_tog, gem_status,
    output s_axis_tready, gem_data, gem_data_ready, gem_data_valid, gem_sop, gem_eop,
           gem_err, gem_underflow, gem_control, gem_dma_tx_status_tog,
           m_status_valid, m_status
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
           gem_data_rd_request, gem_dma_tx_end_tog, gem_status,
    input  s_axis_tready, gem_data, gem_data_ready, gem_data_valid, gem_sop, gem_eop,
           gem_err, gem_underflow, gem_control, gem_dma_tx_status_tog,
           m_status_valid, m_status
  );
endinterface

// File: rtl/gem_ext_fifo_tx_wide_lane_sel.sv
// Byte-lane walker for one stream word: lane counter, lane mux and
// last-valid-lane detection (highest set tkeep bit, lane 0 when tkeep is empty).
module gem_tx_lane_sel
  import gem_ext_fifo_pkg::*;
#(
  parameter int S_KEEP_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [S_KEEP_WIDTH*8-1:0] i_tdata,
  input  logic [S_KEEP_WIDTH-1:0]   i_tkeep,
  input  logic                      i_advance,
  input  logic                      i_clear,
  output logic [7:0]                o_byte,
  output logic                      o_last_lane
);
  localparam int LW = (S_KEEP_WIDTH > 1) ? $clog2(S_KEEP_WIDTH) : 1;

  logic [LW-1:0] r_lane_cnt;
  logic [LW-1:0] w_last_idx;

  always_comb begin
    w_last_idx = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (i_tkeep[i]) w_last_idx = LW'(i);
    end
  end

  always_comb begin
    o_byte = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (r_lane_cnt == LW'(i)) o_byte = i_tdata[i*8 +: 8];
    end
  end

  assign o_last_lane = (r_lane_cnt == w_last_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane_cnt <= '0;
    end else if (i_clear) begin
      r_lane_cnt <= '0;
    end else if (i_advance) begin
      r_lane_cnt <= o_last_lane ? '0 : r_lane_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/gem_ext_fifo_tx_wide.sv
// Wide AXI-Stream to 8-bit GEM external-FIFO TX bridge, one frame in flight,
// with underflow drain and end-toggle timeout. GEM_TX_STATS_EN adds saturating counters.
module gem_ext_fifo_tx_wide
  import gem_ext_fifo_pkg::*;
#(
  parameter int S_DATA_WIDTH = 32,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int END_TIMEOUT  = 65535,
  parameter int CNT_WIDTH    = 32
) (
  input  logic clk,
  input  logic rstn,
  gem_ext_fifo_tx_wide_if.slave io_bus
`ifdef GEM_TX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_frames_ok,
  output logic [CNT_WIDTH-1:0] stat_frames_err,
  output logic [CNT_WIDTH-1:0] stat_underflow,
  output logic [CNT_WIDTH-1:0] stat_timeout
`endif
);
  localparam int TW = $clog2(END_TIMEOUT + 1);

  if ((S_DATA_WIDTH % 8) != 0 || S_DATA_WIDTH < 8 || S_DATA_WIDTH > 64 ||
      S_KEEP_WIDTH * 8 != S_DATA_WIDTH || END_TIMEOUT < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("gem_ext_fifo_tx_wide: illegal parameter set");
  end

  tx_state_e     r_state, w_state_nxt;
  logic          r_armed, r_end_tog_q;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_gem_data;
  logic          r_valid, r_sop, r_eop, r_err, r_uf, r_status_tog, r_m_status_valid;
  logic [4:0]    r_m_status;
  logic          w_tog_chg, w_tmo_hit, w_serve, w_uf, w_word_done, w_eop, w_err;
  logic          w_last_lane;
  logic [7:0]    w_byte;

  gem_tx_lane_sel #(.S_KEEP_WIDTH(S_KEEP_WIDTH)) u_lane_sel (
    .clk         (clk),
    .rstn        (rstn),
    .i_tdata     (io_bus.s_axis_tdata),
    .i_tkeep     (io_bus.s_axis_tkeep),
    .i_advance   (w_serve),
    .i_clear     (r_state == ST_DRAIN),
    .o_byte      (w_byte),
    .o_last_lane (w_last_lane)
  );

  // r_armed keeps the combinational outputs at 0 while reset is (or was just) asserted
  always_comb begin
    w_tog_chg   = io_bus.gem_dma_tx_end_tog ^ r_end_tog_q;
    w_tmo_hit   = (r_state == ST_WAIT_END) && !w_tog_chg && (r_tmo_cnt == '0);
    w_serve     = r_armed && io_bus.gem_data_rd_request && io_bus.s_axis_tvalid &&
                  ((r_state == ST_IDLE) || (r_state == ST_XFER));
    w_uf        = r_armed && io_bus.gem_data_rd_request && !io_bus.s_axis_tvalid &&
                  (r_state == ST_XFER);
    w_word_done = w_serve && w_last_lane;
    w_eop       = w_word_done && io_bus.s_axis_tlast;
    w_err       = w_eop && (io_bus.s_axis_tuser || (io_bus.s_axis_tkeep == '0));
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_serve) w_state_nxt = w_eop ? ST_WAIT_END : ST_XFER;
      ST_XFER:     if (w_eop) w_state_nxt = ST_WAIT_END;
                   else if (w_uf) w_state_nxt = ST_DRAIN;
      ST_DRAIN:    if (r_armed && io_bus.s_axis_tvalid && io_bus.s_axis_tlast) w_state_nxt = ST_WAIT_END;
      ST_WAIT_END: if (w_tog_chg || w_tmo_hit) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= ST_IDLE;
      r_armed          <= 1'b0;
      r_end_tog_q      <= 1'b0;
      r_tmo_cnt        <= '0;
      r_gem_data       <= '0;
      r_valid          <= 1'b0;
      r_sop            <= 1'b0;
      r_eop            <= 1'b0;
      r_err            <= 1'b0;
      r_uf             <= 1'b0;
      r_status_tog     <= 1'b0;
      r_m_status_valid <= 1'b0;
      r_m_status       <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_armed          <= 1'b1;
      r_end_tog_q      <= io_bus.gem_dma_tx_end_tog;
      r_gem_data       <= w_serve ? w_byte : 8'h00;
      r_valid          <= w_serve;
      r_sop            <= w_serve && (r_state == ST_IDLE);
      r_eop            <= w_eop;
      r_err            <= w_err;
      r_uf             <= w_uf;
      r_m_status_valid <= 1'b0;
      if ((r_state == ST_WAIT_END) && w_tog_chg) begin
        r_m_status_valid <= 1'b1;
        r_m_status       <= make_status(1'b0, io_bus.gem_status);
        r_status_tog     <= ~r_status_tog;
      end else if (w_tmo_hit) begin
        r_m_status_valid <= 1'b1;
        r_m_status       <= make_status(1'b1, 4'h0);
      end
      if ((r_state != ST_WAIT_END) && (w_state_nxt == ST_WAIT_END)) begin
        r_tmo_cnt <= TW'(END_TIMEOUT - 1);
      end else if ((r_state == ST_WAIT_END) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
    end
  end

  assign io_bus.s_axis_tready = w_word_done ||
                                (r_armed && (r_state == ST_DRAIN) && io_bus.s_axis_tvalid);
  assign io_bus.gem_data_ready = r_armed && (((r_state == ST_IDLE) && io_bus.s_axis_tvalid) ||
                                             (r_state == ST_XFER));
  assign io_bus.gem_data              = r_gem_data;
  assign io_bus.gem_data_valid        = r_valid;
  assign io_bus.gem_sop               = r_sop;
  assign io_bus.gem_eop               = r_eop;
  assign io_bus.gem_err               = r_err;
  assign io_bus.gem_underflow         = r_uf;
  assign io_bus.gem_control           = 1'b0;
  assign io_bus.gem_dma_tx_status_tog = r_status_tog;
  assign io_bus.m_status_valid        = r_m_status_valid;
  assign io_bus.m_status              = r_m_status;

`ifdef GEM_TX_STATS_EN
  logic [CNT_WIDTH-1:0] r_stat_ok, r_stat_err, r_stat_uf, r_stat_tmo;
  logic                 w_end_hit;

  assign w_end_hit = (r_state == ST_WAIT_END) && w_tog_chg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_ok  <= '0;
      r_stat_err <= '0;
      r_stat_uf  <= '0;
      r_stat_tmo <= '0;
    end else begin
      if (w_end_hit && io_bus.gem_status[GEM_STAT_OK_BIT] && !(&r_stat_ok)) r_stat_ok <= r_stat_ok + 1'b1;
      if (((w_end_hit && !io_bus.gem_status[GEM_STAT_OK_BIT]) || w_tmo_hit) && !(&r_stat_err))
        r_stat_err <= r_stat_err + 1'b1;
      if (w_uf && !(&r_stat_uf)) r_stat_uf <= r_stat_uf + 1'b1;
      if (w_tmo_hit && !(&r_stat_tmo)) r_stat_tmo <= r_stat_tmo + 1'b1;
    end
  end

  assign stat_frames_ok  = r_stat_ok;
  assign stat_frames_err = r_stat_err;
  assign stat_underflow  = r_stat_uf;
  assign stat_timeout    = r_stat_tmo;
`endif
endmodule

// File: tb/tb_gem_ext_fifo_tx_wide.sv
// Directed bench for gem_ext_fifo_tx_wide (32-bit stream, END_TIMEOUT=16).
module tb_gem_ext_fifo_tx_wide;
  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  logic exp_tog  = 1'b0;

  gem_ext_fifo_tx_wide_if #(.S_DATA_WIDTH(32)) bus ();

`ifdef GEM_TX_STATS_EN
  logic [15:0] s_ok, s_err, s_uf, s_tmo;
`endif

  gem_ext_fifo_tx_wide #(
    .S_DATA_WIDTH(32), .END_TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
`ifdef GEM_TX_STATS_EN
    ,
    .stat_frames_ok  (s_ok),
    .stat_frames_err (s_err),
    .stat_underflow  (s_uf),
    .stat_timeout    (s_tmo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] f_data [8];
  logic [3:0]  f_keep [8];
  logic        f_last [8];
  logic        f_user [8];
  int          f_n, f_pops, gap_at, gap_len;
  logic [7:0]  rx [$];
  int          n_sop, sop_idx, n_eop, eop_idx, n_err, n_tready, n_uf, n_uf_bad;
  logic        err_at_eop, ready_at_eop;

  function automatic logic [22:0] all_outs();
    return {bus.gem_data_ready, bus.gem_data_valid, bus.gem_data, bus.gem_sop, bus.gem_eop,
            bus.gem_err, bus.gem_underflow, bus.gem_control, bus.gem_dma_tx_status_tog,
            bus.m_status_valid, bus.m_status, bus.s_axis_tready};
  endfunction

  task automatic idle_inputs();
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
    bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0; bus.gem_data_rd_request = 1'b0;
  endtask

  task automatic load2(input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] k1, input logic u);
    f_data[0] = d0; f_keep[0] = 4'hF; f_last[0] = 1'b0; f_user[0] = 1'b0;
    f_data[1] = d1; f_keep[1] = k1;   f_last[1] = 1'b1; f_user[1] = u;
    f_n = 2; gap_at = -1; gap_len = 0;
  endtask

  // Upstream FIFO + GEM requester: rd held high, one word per tready, optional tvalid gap.
  task automatic send_frame(input int max_cyc, input bit stop_on_eop);
    int gap_left;
    gap_left = gap_len; f_pops = 0; rx.delete();
    n_sop = 0; sop_idx = -1; n_eop = 0; eop_idx = -1; n_err = 0; n_tready = 0;
    n_uf = 0; n_uf_bad = 0; err_at_eop = 1'b0; ready_at_eop = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      bit gap;
      @(negedge clk);
      gap = (f_pops == gap_at) && (gap_left > 0);
      if (gap) gap_left--;
      if (f_pops < f_n && !gap) begin
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = f_data[f_pops]; bus.s_axis_tkeep = f_keep[f_pops];
        bus.s_axis_tlast = f_last[f_pops]; bus.s_axis_tuser = f_user[f_pops];
      end else begin
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
        bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
      end
      bus.gem_data_rd_request = 1'b1;
      #1;
      if (bus.gem_data_valid) begin
        rx.push_back(bus.gem_data);
        if (bus.gem_sop) begin n_sop++; sop_idx = rx.size() - 1; end
        if (bus.gem_eop) begin
          n_eop++; eop_idx = rx.size() - 1; err_at_eop = bus.gem_err; ready_at_eop = bus.gem_data_ready;
        end
      end
      if (bus.gem_err) n_err++;
      if (bus.gem_underflow) begin n_uf++; if (bus.gem_data_valid) n_uf_bad++; end
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin n_tready++; f_pops++; end
      if (stop_on_eop && bus.gem_eop) break;
    end
  endtask

  task automatic pulse_end_tog(input logic [3:0] st);
    @(negedge clk);
    bus.gem_status = st;
    bus.gem_dma_tx_end_tog = ~bus.gem_dma_tx_end_tog;
  endtask

  task automatic test_reset();
    idle_inputs(); rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1; checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_outs: got %0h expected 0", all_outs()); end
    bus.s_axis_tvalid = 1'b1; bus.gem_data_rd_request = 1'b1; #1; checks++;
    if ({bus.gem_data_ready, bus.s_axis_tready} !== 2'b00) begin
      failures++; $display("FAIL reset_comb_gated: got %b expected 00", {bus.gem_data_ready, bus.s_axis_tready});
    end
    idle_inputs();
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    bus.s_axis_tvalid = 1'b1; #1; checks++;
    if (bus.gem_data_ready !== 1'b1) begin failures++; $display("FAIL idle_ready_follows_tvalid: got %b expected 1", bus.gem_data_ready); end
    idle_inputs();
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_b [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load2(32'h04030201, 32'hDEAD0605, 4'h3, 1'b0);
    send_frame(20, 1'b1); idle_inputs();
    checks++;
    if (rx.size() !== 6) begin failures++; $display("FAIL basic_len: got %0d expected 6", rx.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < rx.size()) begin
        checks++;
        if (rx[i] !== exp_b[i]) begin failures++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
      end
    end
    checks++;
    if ({n_sop, sop_idx} !== {32'd1, 32'd0}) begin failures++; $display("FAIL basic_sop: got n=%0d idx=%0d expected n=1 idx=0", n_sop, sop_idx); end
    checks++;
    if ({n_eop, eop_idx} !== {32'd1, 32'd5}) begin failures++; $display("FAIL basic_eop: got n=%0d idx=%0d expected n=1 idx=5", n_eop, eop_idx); end
    checks++;
    if (n_tready !== 2) begin failures++; $display("FAIL basic_tready: got %0d expected 2", n_tready); end
    checks++;
    if ({ready_at_eop, n_err} !== {1'b0, 32'd0}) begin failures++; $display("FAIL basic_ready_err: got ready=%b err=%0d expected ready=0 err=0", ready_at_eop, n_err); end
    pulse_end_tog(4'h1); exp_tog = ~exp_tog;
    @(negedge clk); #1; checks++;
    if ({bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog} !== {1'b1, 5'h01, exp_tog}) begin
      failures++; $display("FAIL basic_status: got v=%b st=%h tog=%b expected v=1 st=01 tog=%b",
                           bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog, exp_tog);
    end
    @(negedge clk); #1; checks++;
    if (bus.m_status_valid !== 1'b0) begin failures++; $display("FAIL basic_status_pulse: got %b expected 0", bus.m_status_valid); end
  endtask

  task automatic test_bad_frame();
    load2(32'h04030201, 32'hDEAD0605, 4'h3, 1'b1);
    send_frame(20, 1'b1); idle_inputs();
    checks++;
    if ({rx.size(), err_at_eop, n_err} !== {32'd6, 1'b1, 32'd1}) begin
      failures++; $display("FAIL bad_err_at_eop: got len=%0d err=%b n_err=%0d expected len=6 err=1 n_err=1", rx.size(), err_at_eop, n_err);
    end
    pulse_end_tog(4'hA); exp_tog = ~exp_tog;
    @(negedge clk); #1; checks++;
    if ({bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog} !== {1'b1, 5'h0A, exp_tog}) begin
      failures++; $display("FAIL bad_status: got v=%b st=%h tog=%b expected v=1 st=0a tog=%b",
                           bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog, exp_tog);
    end
  endtask

  task automatic test_empty_last();
    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    load2(32'h44332211, 32'h555555AA, 4'h0, 1'b0);
    send_frame(20, 1'b1); idle_inputs();
    checks++;
    if ({rx.size(), eop_idx, err_at_eop, n_tready} !== {32'd5, 32'd4, 1'b1, 32'd2}) begin
      failures++; $display("FAIL empty_last: got len=%0d eop_idx=%0d err=%b tready=%0d expected 5 4 1 2",
                           rx.size(), eop_idx, err_at_eop, n_tready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < rx.size()) begin
        checks++;
        if (rx[i] !== exp_b[i]) begin failures++; $display("FAIL empty_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
      end
    end
    pulse_end_tog(4'h1); exp_tog = ~exp_tog;
    @(negedge clk); #1; checks++;
    if ({bus.m_status_valid, bus.m_status} !== {1'b1, 5'h01}) begin
      failures++; $display("FAIL empty_status: got v=%b st=%h expected v=1 st=01", bus.m_status_valid, bus.m_status);
    end
  endtask

  task automatic test_underflow();
    f_data[0] = 32'h14131211; f_keep[0] = 4'hF; f_last[0] = 1'b0; f_user[0] = 1'b0;
    f_data[1] = 32'h18171615; f_keep[1] = 4'hF; f_last[1] = 1'b0; f_user[1] = 1'b0;
    f_data[2] = 32'h00001A19; f_keep[2] = 4'h3; f_last[2] = 1'b1; f_user[2] = 1'b0;
    f_n = 3; gap_at = 1; gap_len = 3;
    send_frame(12, 1'b0); idle_inputs(); #1;
    checks++;
    if ({rx.size(), n_uf, n_uf_bad, n_eop} !== {32'd4, 32'd1, 32'd0, 32'd0}) begin
      failures++; $display("FAIL uf_response: got len=%0d uf=%0d uf_with_valid=%0d eop=%0d expected 4 1 0 0",
                           rx.size(), n_uf, n_uf_bad, n_eop);
    end
    checks++;
    if ({n_tready, f_pops} !== {32'd3, 32'd3}) begin failures++; $display("FAIL uf_drain: got tready=%0d pops=%0d expected 3 3", n_tready, f_pops); end
    checks++;
    if (bus.gem_data_ready !== 1'b0) begin failures++; $display("FAIL uf_ready_wait_end: got %b expected 0", bus.gem_data_ready); end
    pulse_end_tog(4'h1); exp_tog = ~exp_tog;
    @(negedge clk); #1; checks++;
    if ({bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog} !== {1'b1, 5'h01, exp_tog}) begin
      failures++; $display("FAIL uf_status: got v=%b st=%h tog=%b expected v=1 st=01 tog=%b",
                           bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog, exp_tog);
    end
    bus.s_axis_tvalid = 1'b1; #1; checks++;
    if (bus.gem_data_ready !== 1'b1) begin failures++; $display("FAIL uf_back_idle: got %b expected 1", bus.gem_data_ready); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int hit_k;
    hit_k = -1;
    load2(32'h24232221, 32'h00002625, 4'h3, 1'b0);
    send_frame(20, 1'b1); idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (bus.m_status_valid) begin hit_k = k; break; end
    end
    checks++;
    if (hit_k !== 16) begin failures++; $display("FAIL tmo_cycle: got %0d expected 16", hit_k); end
    checks++;
    if ({bus.m_status, bus.gem_dma_tx_status_tog} !== {5'h10, exp_tog}) begin
      failures++; $display("FAIL tmo_status: got st=%h tog=%b expected st=10 tog=%b", bus.m_status, bus.gem_dma_tx_status_tog, exp_tog);
    end
    @(negedge clk); #1; checks++;
    if (bus.m_status_valid !== 1'b0) begin failures++; $display("FAIL tmo_pulse: got %b expected 0", bus.m_status_valid); end
  endtask

  task automatic test_idle_tog();
    int seen;
    seen = 0;
    pulse_end_tog(4'h5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (bus.m_status_valid) seen++;
    end
    checks++;
    if ({seen, bus.gem_dma_tx_status_tog} !== {32'd0, exp_tog}) begin
      failures++; $display("FAIL idle_tog_ignored: got pulses=%0d tog=%b expected 0 %b", seen, bus.gem_dma_tx_status_tog, exp_tog);
    end
  endtask

  task automatic test_reset_mid_xfer();
    load2(32'h04030201, 32'hDEAD0605, 4'h3, 1'b0);
    send_frame(3, 1'b0);
    #2; rstn = 1'b0; #1; checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL mid_reset_outs: got %0h expected 0", all_outs()); end
    exp_tog = 1'b0;
    idle_inputs();
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    load2(32'h0C0B0A09, 32'h00000E0D, 4'h3, 1'b0);
    send_frame(20, 1'b1); idle_inputs();
    checks++;
    if ({rx.size(), n_sop, sop_idx} !== {32'd6, 32'd1, 32'd0}) begin
      failures++; $display("FAIL mid_reset_restart: got len=%0d sop=%0d idx=%0d expected 6 1 0", rx.size(), n_sop, sop_idx);
    end
    if (rx.size() > 0) begin
      checks++;
      if (rx[0] !== 8'h09) begin failures++; $display("FAIL mid_reset_lane0: got %h expected 09", rx[0]); end
    end
    pulse_end_tog(4'h1); exp_tog = ~exp_tog;
    @(negedge clk); #1; checks++;
    if ({bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog} !== {1'b1, 5'h01, exp_tog}) begin
      failures++; $display("FAIL mid_reset_status: got v=%b st=%h tog=%b expected v=1 st=01 tog=%b",
                           bus.m_status_valid, bus.m_status, bus.gem_dma_tx_status_tog, exp_tog);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.gem_dma_tx_end_tog = 1'b0;
    bus.gem_status = 4'h0;
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_bad_frame();
    test_empty_last();
    test_underflow();
    test_timeout();
    test_idle_tog();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
